// File: rtl/param_dist_mem_pkg.sv
// ============================================================================
// param_dist_mem_pkg
// ----------------------------------------------------------------------------
// Purpose : Shared definitions for the parametrised distributed memory and the
//           accumulator datapath that uses it as scratch/register storage.
// Contents: - clear-sequencer state encoding (CLEAR / READY)
//           - even-parity helper used for the optional parity bit
//           - default width/depth constants shared with the datapath
// ============================================================================
package param_dist_mem_pkg;

    // Default geometry: the classic 2K x 16 scratch RAM
    localparam int DEF_DW    = 16;
    localparam int DEF_AW    = 11;
    localparam int DEF_DEPTH = 2048;

    // Widest data word supported; the parity helper works on this width
    localparam int MAX_DW    = 64;

    // Clear sequencer states
    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } clr_state_e;

    // Even parity: returns the bit that makes the total count of ones even.
    // Callers zero-extend narrower words, which does not change the result.
    function automatic logic even_parity(input logic [MAX_DW-1:0] data);
        return ^data;
    endfunction

endpackage : param_dist_mem_pkg

// File: rtl/param_dist_mem_clr_seq.sv
// ============================================================================
// param_dist_mem_clr_seq
// ----------------------------------------------------------------------------
// Purpose : Post-reset clear sweep. After reset drops, walks a pointer from 0
//           to DEPTH-1, one word per clock, then settles in READY. The sweep
//           takes exactly DEPTH cycles; reset at any time restarts it.
// Ports   : i_clk      - clock, rising edge
//           i_rst      - synchronous active-high reset
//           o_busy     - high while the sweep is pending or running
//           o_clr_we   - sweep write request (same as o_busy)
//           o_clr_addr - address the sweep writes this cycle
// ============================================================================
module param_dist_mem_clr_seq
    import param_dist_mem_pkg::*;
#(
    parameter int AW    = DEF_AW,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic          i_clk,
    input  logic          i_rst,
    output logic          o_busy,
    output logic          o_clr_we,
    output logic [AW-1:0] o_clr_addr
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    clr_state_e    r_state;
    clr_state_e    w_state_nxt;
    logic [AW-1:0] r_clr_ptr;
    logic [AW-1:0] w_clr_ptr_nxt;

    // State and sweep pointer registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= CLEAR;
            r_clr_ptr <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_ptr <= w_clr_ptr_nxt;
        end
    end

    // Next-state logic: advance the pointer each cycle of the sweep
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_ptr_nxt = r_clr_ptr;
        case (r_state)
            CLEAR: begin
                if (r_clr_ptr == LAST_ADDR) begin
                    // Last word is written on this edge; park the pointer
                    w_state_nxt   = READY;
                    w_clr_ptr_nxt = '0;
                end else begin
                    w_state_nxt   = CLEAR;
                    w_clr_ptr_nxt = r_clr_ptr + {{(AW-1){1'b0}}, 1'b1};
                end
            end
            READY: begin
                w_state_nxt   = READY;
                w_clr_ptr_nxt = '0;
            end
            default: begin
                w_state_nxt   = CLEAR;
                w_clr_ptr_nxt = '0;
            end
        endcase
    end

    // Status and write-request outputs
    always_comb begin
        o_busy     = (r_state == CLEAR);
        o_clr_we   = (r_state == CLEAR);
        o_clr_addr = r_clr_ptr;
    end

endmodule : param_dist_mem_clr_seq

// File: rtl/param_dist_mem.sv
// ============================================================================
// param_dist_mem
// ----------------------------------------------------------------------------
// Purpose : Parametrised distributed RAM (DEPTH x DW) with a synchronous write
//           port + asynchronous read (port A) and a registered read port B.
//           A built-in sequencer clears every word to INIT_VAL after reset.
// Ports   : i_clk        - clock, rising edge
//           i_rst        - synchronous active-high reset
//           i_a          - port A address (write and async read)
//           i_d          - port A write data
//           i_we         - port A write enable
//           o_spo        - mem[i_a] (0 while busy or out of range)
//           i_dpra       - port B read address
//           o_dpo        - registered mem[i_dpra], write-first on collision
//           o_busy       - high during reset and clear sweep
//           o_parity_err - (PARAM_DIST_MEM_PARITY_EN only) registered parity
//                          check of the word read for o_dpo
// Config  : define PARAM_DIST_MEM_PARITY_EN to store an even-parity bit per
//           word and enable o_parity_err.
// ============================================================================
module param_dist_mem
    import param_dist_mem_pkg::*;
#(
    parameter int          DW       = DEF_DW,
    parameter int          AW       = DEF_AW,
    parameter int          DEPTH    = DEF_DEPTH,
    parameter logic [DW-1:0] INIT_VAL = '0
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [AW-1:0] i_a,
    input  logic [DW-1:0] i_d,
    input  logic          i_we,
    output logic [DW-1:0] o_spo,
    input  logic [AW-1:0] i_dpra,
    output logic [DW-1:0] o_dpo,
    output logic          o_busy
`ifdef PARAM_DIST_MEM_PARITY_EN
    ,
    output logic          o_parity_err
`endif
);

`ifdef PARAM_DIST_MEM_PARITY_EN
    localparam int MW = DW + 1;
    localparam logic [MW-1:0] INIT_WORD = {even_parity(MAX_DW'(INIT_VAL)), INIT_VAL};
`else
    localparam int MW = DW;
    localparam logic [MW-1:0] INIT_WORD = INIT_VAL;
`endif

    // One extra bit so DEPTH == 2**AW is representable
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    logic [MW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_dpo;

    logic          w_busy;
    logic          w_clr_we;
    logic [AW-1:0] w_clr_addr;
    logic          w_a_ok;
    logic          w_dpra_ok;
    logic          w_bypass;
    logic          w_wr_en;
    logic [AW-1:0] w_wr_addr;
    logic [MW-1:0] w_wr_word;
    logic [MW-1:0] w_rd_word;

    param_dist_mem_clr_seq #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_clr_seq (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .o_busy     (w_busy),
        .o_clr_we   (w_clr_we),
        .o_clr_addr (w_clr_addr)
    );

    // Address range checks and write-first collision detect
    always_comb begin
        w_a_ok    = ({1'b0, i_a} < DEPTH_W);
        w_dpra_ok = ({1'b0, i_dpra} < DEPTH_W);
        w_bypass  = i_we && w_dpra_ok && (i_a == i_dpra);
    end

    // Write mux: reset blocks all writes, the sweep owns the array while busy
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_addr = i_a;
`ifdef PARAM_DIST_MEM_PARITY_EN
        w_wr_word = {even_parity(MAX_DW'(i_d)), i_d};
`else
        w_wr_word = i_d;
`endif
        if (i_rst) begin
            w_wr_en = 1'b0;
        end else if (w_clr_we) begin
            w_wr_en   = 1'b1;
            w_wr_addr = w_clr_addr;
            w_wr_word = INIT_WORD;
        end else if (i_we && w_a_ok) begin
            w_wr_en = 1'b1;
        end else begin
            w_wr_en = 1'b0;
        end
    end

    // Storage array (no reset; contents defined by the clear sweep)
    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= w_wr_word;
        end
    end

    // Port B raw read of the pre-edge contents
    always_comb begin
        if (w_dpra_ok) begin
            w_rd_word = r_mem[i_dpra];
        end else begin
            w_rd_word = '0;
        end
    end

    // Port A asynchronous read, forced to 0 while busy or out of range
    always_comb begin
        if (!w_busy && w_a_ok) begin
            o_spo = r_mem[i_a][DW-1:0];
        end else begin
            o_spo = '0;
        end
    end

    // Port B registered read with write-first bypass
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_dpo <= '0;
        end else if (w_busy) begin
            r_dpo <= '0;
        end else if (w_bypass) begin
            r_dpo <= i_d;
        end else begin
            r_dpo <= w_rd_word[DW-1:0];
        end
    end

`ifdef PARAM_DIST_MEM_PARITY_EN
    logic r_parity_err;

    // Parity check of the stored word feeding port B; bypass data is fresh
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_parity_err <= 1'b0;
        end else if (w_busy) begin
            r_parity_err <= 1'b0;
        end else if (w_bypass) begin
            r_parity_err <= 1'b0;
        end else if (w_dpra_ok) begin
            r_parity_err <= (even_parity(MAX_DW'(w_rd_word[DW-1:0])) != w_rd_word[DW]);
        end else begin
            r_parity_err <= 1'b0;
        end
    end

    assign o_parity_err = r_parity_err;
`endif

    assign o_dpo  = r_dpo;
    assign o_busy = w_busy;

endmodule : param_dist_mem

// File: tb/tb_param_dist_mem.sv
// ============================================================================
// tb_param_dist_mem
// ----------------------------------------------------------------------------
// Directed bench for param_dist_mem. dut0 uses the default 2048 x 16 geometry
// with INIT_VAL 0; dut1 uses DEPTH=1000, AW=10, INIT_VAL=16'h00FF.
// Optional parity checks are built when PARAM_DIST_MEM_PARITY_EN is defined.
// ============================================================================
module tb_param_dist_mem;

    localparam int SWEEP_LIMIT = 5000;

    logic        clk;
    int          n_checks;
    int          n_errors;
    int          cnt;

    // dut0: default geometry
    logic        rst0;
    logic [10:0] a0;
    logic [15:0] d0;
    logic        we0;
    logic [15:0] spo0;
    logic [10:0] dpra0;
    logic [15:0] dpo0;
    logic        busy0;
`ifdef PARAM_DIST_MEM_PARITY_EN
    logic        perr0;
    logic        perr1;
`endif

    // dut1: non-power-of-2 depth
    logic        rst1;
    logic [9:0]  a1;
    logic [15:0] d1;
    logic        we1;
    logic [15:0] spo1;
    logic [9:0]  dpra1;
    logic [15:0] dpo1;
    logic        busy1;

    param_dist_mem dut0 (
        .i_clk        (clk),
        .i_rst        (rst0),
        .i_a          (a0),
        .i_d          (d0),
        .i_we         (we0),
        .o_spo        (spo0),
        .i_dpra       (dpra0),
        .o_dpo        (dpo0),
        .o_busy       (busy0)
`ifdef PARAM_DIST_MEM_PARITY_EN
        ,
        .o_parity_err (perr0)
`endif
    );

    param_dist_mem #(
        .DW       (16),
        .AW       (10),
        .DEPTH    (1000),
        .INIT_VAL (16'h00FF)
    ) dut1 (
        .i_clk        (clk),
        .i_rst        (rst1),
        .i_a          (a1),
        .i_d          (d1),
        .i_we         (we1),
        .o_spo        (spo1),
        .i_dpra       (dpra1),
        .o_dpo        (dpo1),
        .o_busy       (busy1)
`ifdef PARAM_DIST_MEM_PARITY_EN
        ,
        .o_parity_err (perr1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled and inputs driven 1 ns later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Count cycles until dut0 busy drops (bounded)
    task automatic wait_sweep0(output int n);
        n = 0;
        while (busy0 && n < SWEEP_LIMIT) begin
            step();
            n = n + 1;
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst0 = 1'b1; a0 = '0; d0 = '0; we0 = 1'b0; dpra0 = '0;
        rst1 = 1'b1; a1 = '0; d1 = '0; we1 = 1'b0; dpra1 = '0;

        // ---- 1. reset and clear sweep, default geometry ----
        repeat (3) step();
        check_val("rst_busy", 64'(busy0), 64'd1);
        check_val("rst_dpo", 64'(dpo0), 64'h0);
        check_val("rst_spo", 64'(spo0), 64'h0);
`ifdef PARAM_DIST_MEM_PARITY_EN
        check_val("rst_perr", 64'(perr0), 64'd0);
`endif
        rst0 = 1'b0;
        wait_sweep0(cnt);
        check_val("sweep_len_2048", 64'(cnt), 64'd2048);
        for (int i = 1; i <= 3; i++) begin
            a0 = 11'(i);
            dpra0 = 11'(i);
            step();
            check_val("clr_spo", 64'(spo0), 64'h0);
            check_val("clr_dpo", 64'(dpo0), 64'h0);
        end

        // ---- 2. write then read ----
        we0 = 1'b1; a0 = 11'd1; d0 = 16'hBEEF; dpra0 = 11'd0;
        step();
        check_val("wr1_spo", 64'(spo0), 64'hBEEF);
        a0 = 11'd2; d0 = 16'h1234;
        step();
        we0 = 1'b0;
        #1;
        check_val("wr2_spo", 64'(spo0), 64'h1234);
        dpra0 = 11'd1;
        step();
        check_val("rd1_dpo", 64'(dpo0), 64'hBEEF);
        dpra0 = 11'd2; a0 = 11'd1;
        step();
        check_val("rd2_dpo", 64'(dpo0), 64'h1234);
        check_val("rd1_spo", 64'(spo0), 64'hBEEF);

        // ---- 3. write-first collision ----
        we0 = 1'b1; a0 = 11'd5; dpra0 = 11'd5; d0 = 16'hA5A5;
        step();
        check_val("wf_dpo", 64'(dpo0), 64'hA5A5);
        we0 = 1'b0;
        step();
        check_val("wf_stored", 64'(dpo0), 64'hA5A5);

`ifdef PARAM_DIST_MEM_PARITY_EN
        // ---- 6. parity ----
        we0 = 1'b1; a0 = 11'd8; d0 = 16'h0001; dpra0 = 11'd2;
        step();
        check_val("par_rd_ok", 64'(perr0), 64'd0);
        a0 = 11'd9; d0 = 16'h00F3;
        step();
        we0 = 1'b0; dpra0 = 11'd9;
        step();
        check_val("par_ok9", 64'(perr0), 64'd0);
        check_val("par_dpo9", 64'(dpo0), 64'h00F3);
        dut0.r_mem[9][0] = ~dut0.r_mem[9][0];
        step();
        check_val("par_err9", 64'(perr0), 64'd1);
        dpra0 = 11'd8;
        step();
        check_val("par_clr8", 64'(perr0), 64'd0);
`endif

        // ---- 5. reset in READY with a write, then reset mid-sweep ----
        rst0 = 1'b1; we0 = 1'b1; a0 = 11'd7; d0 = 16'hCAFE;
        step();
        check_val("rstw_busy", 64'(busy0), 64'd1);
        check_val("rstw_dpo", 64'(dpo0), 64'h0);
        rst0 = 1'b0; we0 = 1'b0;
        repeat (500) step();
        check_val("mid_busy", 64'(busy0), 64'd1);
        rst0 = 1'b1;
        step();
        rst0 = 1'b0;
        wait_sweep0(cnt);
        check_val("resweep_len", 64'(cnt), 64'd2048);
        a0 = 11'd7; dpra0 = 11'd5;
        step();
        check_val("rst_wr_drop", 64'(spo0), 64'h0);
        check_val("resweep_a5", 64'(dpo0), 64'h0);
        a0 = 11'd1;
        #1;
        check_val("resweep_a1", 64'(spo0), 64'h0);

        // ---- 4. non-power-of-2 depth, INIT_VAL 00FF ----
        step();
        rst1 = 1'b0;
        cnt = 0;
        while (busy1 && cnt < SWEEP_LIMIT) begin
            // A write attempt to an already-swept word must be ignored
            if (cnt == 500) begin
                we1 = 1'b1; a1 = 10'd3; d1 = 16'hDEAD;
            end else begin
                we1 = 1'b0; a1 = 10'd0;
            end
            step();
            cnt = cnt + 1;
            if (cnt == 501) begin
                check_val("busy_spo", 64'(spo1), 64'h0);
            end
        end
        we1 = 1'b0;
        check_val("sweep_len_1000", 64'(cnt), 64'd1000);
        a1 = 10'd3;
        #1;
        check_val("busy_wr_drop", 64'(spo1), 64'h00FF);
        we1 = 1'b1; a1 = 10'd999; d1 = 16'h7777;
        step();
        check_val("wr999_spo", 64'(spo1), 64'h7777);
        a1 = 10'd1000; d1 = 16'h1111;
        step();
        we1 = 1'b0;
        #1;
        check_val("oor_spo", 64'(spo1), 64'h0);
        dpra1 = 10'd1000;
        step();
        check_val("oor_dpo", 64'(dpo1), 64'h0);
        dpra1 = 10'd999; a1 = 10'd0;
        step();
        check_val("rd999_dpo", 64'(dpo1), 64'h7777);
        check_val("init0_spo", 64'(spo1), 64'h00FF);
        a1 = 10'd998;
        #1;
        check_val("init998_spo", 64'(spo1), 64'h00FF);
        a1 = 10'd1023;
        #1;
        check_val("oor1023_spo", 64'(spo1), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_param_dist_mem

// File: doc/param_dist_mem.md
Name: param_dist_mem

Overview:
- Parametrised successor to the fixed 2K x 16 distributed RAM.
- Width, depth and power-up contents are configurable.
- Port A has a synchronous write and an asynchronous read (spo). A second read port (dpra/dpo) is registered.
- A built-in clear sequencer sweeps every word to INIT_VAL after reset. It serves as the register-file / scratch memory for the accumulator datapath.

Parameters:
DW, 16, data word width in bits (1..64)
AW, 11, address width in bits
DEPTH, 2048, number of words; 2 <= DEPTH <= 2**AW; need not be a power of 2
INIT_VAL, 0, DW-bit value written to every word by the clear sweep

Ports:
clk  in  1  single clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
a  in  AW  port A address (write and async read)
d  in  DW  port A write data
we  in  1  port A write enable, sampled on rising clk
spo  out  DW  port A asynchronous read data of mem[a]
dpra  in  AW  port B read address
dpo  out  DW  port B registered read data, 1-cycle latency
busy  out  1  high during reset and clear sweep; the memory is unusable while high

Behaviour:
- FSM states: CLEAR, READY.
  - rst=1 at any edge (including mid-sweep or in READY): state<=CLEAR, clr_ptr<=0, dpo<=0.
  - CLEAR: each edge with rst=0 writes INIT_VAL to mem[clr_ptr], then clr_ptr++.
  - When clr_ptr==DEPTH-1 is written, state<=READY.
  - The sweep takes exactly DEPTH cycles after rst falls.
- busy: combinational, busy = (state==CLEAR).
  - Reset value 1.
  - Goes low on the edge that writes the last word.
- While busy:
  - we is ignored (the user write is dropped, no queuing).
  - spo reads 0.
  - dpo registers 0.
- Write (READY): at a rising edge with we=1 and a<DEPTH, mem[a]<=d.
  - we=1 with a>=DEPTH: the write is dropped and no other word changes.
- spo:
  - Combinational mem[a] when READY and a<DEPTH, else 0.
  - After a write edge, spo shows the new data in the same cycle (after the edge).
- dpo:
  - At each edge in READY: dpo <= (dpra<DEPTH) ? mem[dpra] : 0.
  - Write-first: if we=1 and a==dpra on the same edge, dpo takes d, not the old contents.
- Simultaneous rst and we: rst wins, the write is dropped.
- Memory contents are undefined only before the first completed sweep.

Optional Feature:
- Macro: PARAM_DIST_MEM_PARITY_EN.
- Defined:
  - Each word stores DW+1 bits; the extra bit is the even parity of the data (the clear sweep stores the parity of INIT_VAL).
  - Extra output port parity_err (1 bit, registered, reset 0).
  - On each READY edge: parity_err <= 1 if the parity recomputed from the word read for dpo mismatches its stored bit.
  - The write-first bypass and out-of-range reads give parity_err<=0.
  - parity_err<=0 whenever busy.
- Undefined: no parity storage and no parity_err port. The storage is exactly DEPTH x DW.

Decomposition:
- Shared package param_dist_mem_pkg holds:
  - the state encoding (CLEAR=1'b0, READY=1'b1);
  - the even-parity function;
  - the default DW/AW/DEPTH constants shared with the datapath.
- One natural sub-module: param_dist_mem_clr_seq (FSM + clr_ptr counter; outputs busy, clr_we, clr_addr).
- The top module muxes the clear-sequencer write signals (clr_we, clr_addr) against the user write, and holds the array and the dpo register.

Test Plan:
1. Reset/clear, default params:
   - rst high 3 cycles, then low.
   - busy=1 for exactly 2048 cycles after rst falls, then 0.
   - Afterwards spo=0 and dpo=0 at a=1, 2, 3.
2. Write then read:
   - we=1, a=1, d=16'hBEEF; next cycle a=2, d=16'h1234.
   - spo=16'hBEEF at a=1 right after the first edge.
   - dpra=1 gives dpo=16'hBEEF one edge later.
3. Write-first collision: we=1, a=dpra=5, d=16'hA5A5 on one edge -> dpo=16'hA5A5 on that same edge.
4. Non-power-of-2 and boundary, DEPTH=1000, AW=10, INIT_VAL=16'h00FF:
   - Sweep takes 1000 cycles.
   - Write a=999 d=16'h7777 succeeds.
   - Write a=1000 d=16'h1111 is dropped; spo/dpo read 0 at a=1000.
   - mem[0] still reads 16'h00FF.
5. Reset mid-operation:
   - Assert rst at sweep cycle 500 for 1 cycle -> the sweep restarts and busy stays high 2048 more cycles.
   - Assert rst in READY with we=1, a=7, d=16'hCAFE -> the write is dropped and mem[7] reads INIT_VAL after the re-sweep.
6. PARAM_DIST_MEM_PARITY_EN:
   - Normal writes/reads keep parity_err=0.
   - The bench flips a stored data bit of mem[9] hierarchically; a read with dpra=9 gives parity_err=1 for one cycle.
   - A read with dpra=8 on the next cycle gives parity_err=0.
